// File: rtl/sw_debouncer.sv
// sw_debouncer: per-bit two-flop synchronizer plus hold-time debounce with registered edge pulses
module sw_debouncer #(
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_stable,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            any_change
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [N_SW-1:0]  sync1, sync2, diff, done;
  logic [CNT_W-1:0] cnt [N_SW];
  assign diff = sync2 ^ sw_stable;
  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    assign done[i] = diff[i] && cnt[i] == LIM;
    // counter saturates at LIM: qualification clears it on the same edge
    always_ff @(posedge clock or posedge reset)
      if (reset) cnt[i] <= '0;
      else       cnt[i] <= (diff[i] && !done[i]) ? cnt[i] + 1'b1 : '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      sw_stable  <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      any_change <= 1'b0;
    end else begin
      sync1      <= sw_raw;
      sync2      <= sync1;
      sw_stable  <= sw_stable ^ done;
      sw_rise    <= done & sync2;
      sw_fall    <= done & ~sync2;
      any_change <= |done;
    end
endmodule

// File: tb/tb_sw_debouncer.sv
// tb_sw_debouncer: directed checks of sw_debouncer with DEBOUNCE_CYCLES=4, N_SW=10
module tb_sw_debouncer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] sw_raw = '0;
  logic [9:0] sw_stable, sw_rise, sw_fall;
  logic       any_change;
  int         tests = 0, fails = 0;

  sw_debouncer #(.N_SW(10), .DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .clock(clock), .reset(reset), .sw_raw(sw_raw), .sw_stable(sw_stable),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .any_change(any_change)
  );

  always #5 clock = ~clock;

  // inputs change at a negedge; the next posedge is edge 0 and samples land on the following negedges
  task automatic settle(input logic [9:0] v);
    sw_raw = v;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if ({sw_stable, sw_rise, sw_fall, any_change} !== '0) begin
      fails++;
      $display("FAIL reset_state: got stable=%h rise=%h fall=%h chg=%b, need all 0", sw_stable, sw_rise, sw_fall, any_change);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    tests++;
    if ({sw_stable, sw_rise, sw_fall, any_change} !== '0) begin
      fails++;
      $display("FAIL post_release_quiet: got stable=%h rise=%h fall=%h chg=%b, need all 0", sw_stable, sw_rise, sw_fall, any_change);
    end
  endtask

  task automatic test_rise;
    sw_raw = 10'h001;
    for (int e = 0; e <= 6; e++) begin
      @(negedge clock);
      tests++;
      if (sw_stable !== (e >= 5 ? 10'h001 : 10'h000) || sw_rise !== (e == 5 ? 10'h001 : 10'h000) ||
          sw_fall !== 10'h000 || any_change !== (e == 5)) begin
        fails++;
        $display("FAIL rise_edge%0d: got stable=%h rise=%h fall=%h chg=%b", e, sw_stable, sw_rise, sw_fall, any_change);
      end
    end
  endtask

  task automatic test_fall;
    sw_raw = 10'h000;
    for (int e = 0; e <= 6; e++) begin
      @(negedge clock);
      tests++;
      if (sw_stable !== (e >= 5 ? 10'h000 : 10'h001) || sw_fall !== (e == 5 ? 10'h001 : 10'h000) ||
          sw_rise !== 10'h000 || any_change !== (e == 5)) begin
        fails++;
        $display("FAIL fall_edge%0d: got stable=%h rise=%h fall=%h chg=%b", e, sw_stable, sw_rise, sw_fall, any_change);
      end
    end
  endtask

  task automatic test_glitch;
    int pulses = 0;
    sw_raw = 10'h001;
    repeat (3) @(negedge clock);
    sw_raw = 10'h000;
    for (int e = 0; e < 10; e++) begin
      @(negedge clock);
      if (sw_rise !== '0 || sw_fall !== '0 || any_change !== 1'b0) pulses++;
    end
    tests++;
    if (sw_stable !== 10'h000 || pulses != 0) begin
      fails++;
      $display("FAIL glitch_reject: got stable=%h pulses=%0d, need stable=000 pulses=0", sw_stable, pulses);
    end
  endtask

  task automatic test_bounce;
    int rises = 0;
    logic [3:0] seq = 4'b1010;
    for (int j = 3; j >= 0; j--) begin
      sw_raw = {8'h00, seq[j], 1'b0};
      @(negedge clock);
      if (sw_rise[1]) rises++;
    end
    sw_raw = 10'h002;
    for (int e = 0; e <= 7; e++) begin
      @(negedge clock);
      if (sw_rise[1]) rises++;
      if (e == 4 || e == 5) begin
        tests++;
        if (sw_stable[1] !== (e == 5)) begin
          fails++;
          $display("FAIL bounce_edge%0d: got stable[1]=%b, need %b", e, sw_stable[1], e == 5);
        end
      end
    end
    tests++;
    if (rises != 1) begin
      fails++;
      $display("FAIL bounce_rise_count: got %0d, need 1", rises);
    end
  endtask

  task automatic test_simultaneous;
    int changes = 0;
    settle(10'h200);
    tests++;
    if (sw_stable !== 10'h200) begin
      fails++;
      $display("FAIL simul_setup: got stable=%h, need 200", sw_stable);
    end
    sw_raw = 10'h003;
    for (int e = 0; e <= 6; e++) begin
      @(negedge clock);
      if (any_change) changes++;
      if (e >= 4) begin
        tests++;
        if (sw_stable !== (e >= 5 ? 10'h003 : 10'h200) || sw_rise !== (e == 5 ? 10'h003 : 10'h000) ||
            sw_fall !== (e == 5 ? 10'h200 : 10'h000) || any_change !== (e == 5)) begin
          fails++;
          $display("FAIL simul_edge%0d: got stable=%h rise=%h fall=%h chg=%b", e, sw_stable, sw_rise, sw_fall, any_change);
        end
      end
    end
    tests++;
    if (changes != 1) begin
      fails++;
      $display("FAIL simul_change_count: got %0d, need 1", changes);
    end
  endtask

  task automatic test_reset_midcount;
    settle(10'h001);
    sw_raw = 10'h201;
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({sw_stable, sw_rise, sw_fall, any_change} !== '0) begin
      fails++;
      $display("FAIL async_reset: got stable=%h rise=%h fall=%h chg=%b, need all 0", sw_stable, sw_rise, sw_fall, any_change);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      @(negedge clock);
      tests++;
      if (sw_rise !== (e == 5 ? 10'h201 : 10'h000) || sw_stable !== (e >= 5 ? 10'h201 : 10'h000) ||
          sw_fall !== 10'h000) begin
        fails++;
        $display("FAIL restart_edge%0d: got stable=%h rise=%h fall=%h", e, sw_stable, sw_rise, sw_fall);
      end
    end
  endtask

  initial begin
    test_reset;
    test_rise;
    test_fall;
    test_glitch;
    test_bounce;
    test_simultaneous;
    test_reset_midcount;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sw_debouncer.md
SW_DEBOUNCER -- requirements
Module: sw_debouncer

Interface
REQ-001 Parameter N_SW, default 10: number of independent switch inputs conditioned.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz): stable-hold time in clock cycles; legal range 1 to 2^CNT_W-1.
REQ-003 Parameter CNT_W, default 20: width of each per-bit debounce counter.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clock  input  1  system clock (50 MHz board clock); all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset of all state.
REQ-007 sw_raw  input  N_SW  raw, asynchronous, bouncing switch levels.
REQ-008 sw_stable  output  N_SW  debounced switch levels; drives counter clear and rate-select controls downstream.
REQ-009 sw_rise  output  N_SW  one-cycle pulse per bit on a debounced 0->1 transition.
REQ-010 sw_fall  output  N_SW  one-cycle pulse per bit on a debounced 1->0 transition.
REQ-011 any_change  output  1  one-cycle pulse, OR of all sw_rise and sw_fall bits; used downstream to restart the rate divider on a rate change.

Function
REQ-012 Each bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic; no logic SHALL use sw_raw directly.
REQ-013 Each bit SHALL own one CNT_W-bit counter; bits SHALL be fully independent.
REQ-014 Per bit, each cycle: if sync2 == sw_stable, the counter SHALL clear to 0.
REQ-015 Per bit, each cycle: if sync2 != sw_stable and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-016 Per bit, each cycle: if sync2 != sw_stable and counter == DEBOUNCE_CYCLES-1, then on that edge sw_stable SHALL take sync2 and the counter SHALL clear to 0.
REQ-017 The counter SHALL never wrap or exceed DEBOUNCE_CYCLES-1.
REQ-018 Latency: a sw_raw level first sampled at edge k and held SHALL appear on sw_stable after edge k+1+DEBOUNCE_CYCLES.
REQ-019 Any excursion of sync2 from sw_stable lasting fewer than DEBOUNCE_CYCLES cycles SHALL leave sw_stable unchanged and SHALL clear the counter on its return.
REQ-020 sw_rise[i] and sw_fall[i] SHALL be registered and asserted for exactly the one cycle following the edge on which sw_stable[i] changes.
REQ-021 sw_rise[i] and sw_fall[i] SHALL never both be high.
REQ-022 any_change SHALL be registered and aligned with the rise/fall pulses.
REQ-023 Simultaneous qualification on several bits in one cycle SHALL update all of them on that edge and produce one any_change pulse.
REQ-024 When DEBOUNCE_CYCLES == 1, a single differing sync2 cycle SHALL update sw_stable on that edge.

Reset
REQ-025 On reset assertion, independent of clock, sync1, sync2, sw_stable, all counters, sw_rise, sw_fall and any_change SHALL go to 0.
REQ-026 Reset asserted mid-count SHALL discard the partial count; after release, debouncing SHALL restart from 0 against sw_stable = 0.
REQ-027 Immediately after reset release, no rise, fall or change pulse SHALL be produced unless a bit qualifies under REQ-016.
REQ-028 A switch held at 1 through reset SHALL produce a sw_rise pulse DEBOUNCE_CYCLES+2 edges after release.

Verification (bench: DEBOUNCE_CYCLES=4, N_SW=10)
REQ-029 Reset, then drive sw_raw=0x001 steady from edge 0 -> sw_stable=0x001 after edge 5; sw_rise=0x001 and any_change=1 for exactly one cycle; sw_fall=0.
REQ-030 sw_stable=0x000, then pulse sw_raw[0] high for 3 cycles only -> sw_stable stays 0x000; no pulses.
REQ-031 Bounce sw_raw[1] 1,0,1,0,1 at one cycle each, then hold 1 -> sw_stable[1] rises 6 edges after the final 0->1, with a single sw_rise[1] pulse.
REQ-032 sw_stable=0x200, then drive sw_raw 0x200->0x003 on the same edge -> on the same edge sw_stable=0x003, sw_rise=0x003, sw_fall=0x200, and one any_change pulse.
REQ-033 Assert reset asynchronously between clock edges while counter[9]=2 -> all outputs 0 immediately; after release with sw_raw[9]=1 held, sw_rise[9] fires after edge 5.
